// File: rtl/outfifo_arbiter.sv
// Merges per-thread output FIFOs onto one stream with packet-granular round-robin grants.
// state | meaning
// IDLE  | one arbitration cycle: pick next thread holding a complete packet
// XFER  | pop and forward the granted thread's packet until its last word
module outfifo_arbiter #(
    parameter int NUM_THREADS = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int CTRL_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_THREADS-1:0]            pkt_avail,
    input  logic [NUM_THREADS-1:0]            in_valid,
    input  logic [NUM_THREADS-1:0]            in_last,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0] in_ctrl,
    output logic [NUM_THREADS-1:0]            rd_en,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic                              out_wr,
    input  logic                              out_rdy,
    output logic [2:0]                        thread_sel,
    output logic [NUM_THREADS-1:0]            pkt_done
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state;
    logic [2:0]            last_grant;
    logic [7:0]            avail_arr;
    logic [7:0]            valid_arr;
    logic [7:0]            last_arr;
    logic [DATA_WIDTH-1:0] data_arr [8];
    logic [CTRL_WIDTH-1:0] ctrl_arr [8];
    logic                  pop;
    logic                  rr_found;
    logic [2:0]            rr_winner;
    logic [3:0]            rr_idx;

    // Pad per-thread inputs to eight lanes so a 3-bit thread index is always in range.
    for (genvar g = 0; g < 8; g++) begin : g_lane
        if (g < NUM_THREADS) begin : g_used
            assign avail_arr[g] = pkt_avail[g];
            assign valid_arr[g] = in_valid[g];
            assign last_arr[g]  = in_last[g];
            assign data_arr[g]  = in_data[g*DATA_WIDTH +: DATA_WIDTH];
            assign ctrl_arr[g]  = in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
            assign rd_en[g]     = pop && (thread_sel == 3'(g));
        end else begin : g_unused
            assign avail_arr[g] = 1'b0;
            assign valid_arr[g] = 1'b0;
            assign last_arr[g]  = 1'b0;
            assign data_arr[g]  = '0;
            assign ctrl_arr[g]  = '0;
        end
    end

    assign pop = (state == XFER) && valid_arr[thread_sel] && out_rdy;

    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            rr_idx = {1'b0, last_grant} + 4'(k);
            if (rr_idx >= 4'(NUM_THREADS)) begin
                rr_idx = rr_idx - 4'(NUM_THREADS);
            end
            if (!rr_found && avail_arr[rr_idx[2:0]]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx[2:0];
            end
        end
    end

    // last_grant resets to the top thread so thread 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            thread_sel <= '0;
            last_grant <= 3'(NUM_THREADS - 1);
            out_wr     <= 1'b0;
            out_data   <= '0;
            out_ctrl   <= '0;
            pkt_done   <= '0;
        end else begin
            out_wr   <= 1'b0;
            pkt_done <= '0;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        thread_sel <= rr_winner;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (pop) begin
                        out_wr   <= 1'b1;
                        out_data <= data_arr[thread_sel];
                        out_ctrl <= ctrl_arr[thread_sel];
                        if (last_arr[thread_sel]) begin
                            state      <= IDLE;
                            last_grant <= thread_sel;
                            pkt_done   <= rd_en;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_outfifo_arbiter.sv
// Bench for outfifo_arbiter: behavioural thread FIFOs plus a round-robin packet-order model.
module tb_outfifo_arbiter;
    localparam int NT    = 8;
    localparam int DW    = 64;
    localparam int CW    = 8;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NT-1:0]     pkt_avail;
    logic [NT-1:0]     in_valid;
    logic [NT-1:0]     in_last;
    logic [NT*DW-1:0]  in_data;
    logic [NT*CW-1:0]  in_ctrl;
    logic [NT-1:0]     rd_en;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy;
    logic [2:0]        thread_sel;
    logic [NT-1:0]     pkt_done;

    outfifo_arbiter #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .pkt_avail(pkt_avail), .in_valid(in_valid),
        .in_last(in_last), .in_data(in_data), .in_ctrl(in_ctrl), .rd_en(rd_en),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .thread_sel(thread_sel), .pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        bit            last;
        int            thr;
    } exp_t;

    exp_t          exp_out[$];
    exp_t          exp_pop[$];
    logic [DW-1:0] mem_d [NT][DEPTH];
    logic [CW-1:0] mem_c [NT][DEPTH];
    bit            mem_l [NT][DEPTH];
    int            wr_ptr [NT];
    int            rd_ptr [NT];
    int            pkts_left [NT];
    int            pk_len [NT][16];
    int            pk_cnt [NT];
    int            model_last;
    int            checks = 0;
    int            errors = 0;
    int            cyc;
    bit            prev_pop;
    logic [DW-1:0] hold_d;
    logic [CW-1:0] hold_c;
    int            gap_thr, gap_a, gap_len, rdy_a, rdy_len;
    bit            rnd_mode;
    int            last_done_cyc;
    int            done_order[$];
    int            exp_order[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_fifos();
        for (int t = 0; t < NT; t++) begin
            rd_ptr[t] = 0; wr_ptr[t] = 0; pkts_left[t] = 0; pk_cnt[t] = 0;
        end
    endtask

    task automatic add_pkt(input int t, input int len);
        for (int i = 0; i < len; i++) begin
            mem_d[t][wr_ptr[t]] = {$urandom, $urandom};
            mem_c[t][wr_ptr[t]] = CW'($urandom);
            mem_l[t][wr_ptr[t]] = (i == len - 1);
            wr_ptr[t]++;
        end
        pk_len[t][pk_cnt[t]] = len;
        pk_cnt[t]++;
        pkts_left[t]++;
    endtask

    // Expected output order: whole packets, next thread after the last grant that still has one.
    task automatic plan();
        int   wp [NT];
        int   pi [NT];
        int   total;
        exp_t e;
        total = 0;
        for (int t = 0; t < NT; t++) begin
            wp[t] = rd_ptr[t]; pi[t] = 0; total += pk_cnt[t];
        end
        for (int p = 0; p < total; p++) begin
            for (int k = 1; k <= NT; k++) begin
                int t;
                t = (model_last + k) % NT;
                if (pi[t] < pk_cnt[t]) begin
                    for (int w = 0; w < pk_len[t][pi[t]]; w++) begin
                        e.d = mem_d[t][wp[t]]; e.c = mem_c[t][wp[t]];
                        e.last = mem_l[t][wp[t]]; e.thr = t;
                        exp_out.push_back(e); exp_pop.push_back(e);
                        wp[t]++;
                    end
                    pi[t]++;
                    model_last = t;
                    break;
                end
            end
        end
    endtask

    task automatic drive();
        bit has, gap;
        for (int t = 0; t < NT; t++) begin
            has = rd_ptr[t] < wr_ptr[t];
            gap = (t == gap_thr) && (cyc >= gap_a) && (cyc < gap_a + gap_len);
            if (rnd_mode && $urandom_range(0, 4) == 0) gap = 1'b1;
            pkt_avail[t]         = pkts_left[t] > 0;
            in_valid[t]          = has && !gap;
            in_last[t]           = has ? mem_l[t][rd_ptr[t]] : 1'b0;
            in_data[t*DW +: DW]  = has ? mem_d[t][rd_ptr[t]] : '0;
            in_ctrl[t*CW +: CW]  = has ? mem_c[t][rd_ptr[t]] : '0;
        end
        out_rdy = !((cyc >= rdy_a) && (cyc < rdy_a + rdy_len));
        if (rnd_mode && $urandom_range(0, 3) == 0) out_rdy = 1'b0;
    endtask

    // One clock: drive at negedge, check registered outputs and rd_en, retire pops at posedge.
    task automatic step();
        exp_t e;
        bit   pop_now;
        int   t;
        drive();
        #1;
        chk("out_wr_latency", 64'(out_wr), 64'(prev_pop));
        chk("rd_en_onehot0", 64'($onehot0(rd_en)), 64'd1);
        if (out_wr) begin
            if (exp_out.size() == 0) begin
                chk("unexpected_word", 64'(out_wr), 64'd0);
            end else begin
                e = exp_out.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_ctrl", 64'(out_ctrl), 64'(e.c));
                chk("thread_sel", 64'(thread_sel), 64'(e.thr));
                chk("pkt_done", 64'(pkt_done), e.last ? (64'd1 << e.thr) : 64'd0);
                hold_d = e.d; hold_c = e.c;
                if (e.last) begin
                    last_done_cyc = cyc;
                    done_order.push_back(e.thr);
                    chk("rd_en_in_arb_cycle", 64'(rd_en), 64'd0);
                end
            end
        end else begin
            chk("pkt_done_idle", 64'(pkt_done), 64'd0);
            chk("out_data_hold", out_data, hold_d);
            chk("out_ctrl_hold", 64'(out_ctrl), 64'(hold_c));
        end
        if (rd_en != '0) begin
            if (exp_pop.size() == 0) begin
                chk("unexpected_pop", 64'(rd_en), 64'd0);
            end else begin
                chk("rd_en_thread", 64'(rd_en), 64'd1 << exp_pop[0].thr);
                chk("rd_en_qualified", 64'(in_valid[exp_pop[0].thr] && out_rdy), 64'd1);
            end
        end
        pop_now = |rd_en;
        @(posedge clk);
        if (pop_now && exp_pop.size() > 0) begin
            e = exp_pop.pop_front();
            t = e.thr;
            if (rd_ptr[t] < wr_ptr[t]) begin
                if (mem_l[t][rd_ptr[t]]) pkts_left[t]--;
                rd_ptr[t]++;
            end
        end
        prev_pop = pop_now;
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_masks(input int gt, input int ga, input int gl, input int ra, input int rl, input bit rnd);
        gap_thr = gt; gap_a = ga; gap_len = gl; rdy_a = ra; rdy_len = rl; rnd_mode = rnd;
    endtask

    task automatic run_phase(input int max_cyc, input int exp_done);
        cyc = 0;
        last_done_cyc = -1;
        done_order.delete();
        plan();
        while ((exp_out.size() > 0 || prev_pop) && cyc < max_cyc) step();
        chk("phase_words_left", 64'(exp_out.size()), 64'd0);
        if (exp_done >= 0) chk("phase_done_cycle", 64'(last_done_cyc), 64'(exp_done));
        rnd_mode = 1'b0;
        step();
        step();
        exp_out.delete(); exp_pop.delete();
        clear_fifos();
    endtask

    task automatic chk_order();
        chk("grant_count", 64'(done_order.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < done_order.size(); i++) begin
            chk("grant_order", 64'(done_order[i]), 64'(exp_order[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        pkt_avail = '0; in_valid = '0; in_last = '0; in_data = '0; in_ctrl = '0; out_rdy = 1'b0;
        clear_fifos();
        set_masks(-1, 0, 0, -1, 0, 1'b0);
        model_last = NT - 1;
        prev_pop = 1'b0; hold_d = '0; hold_c = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_thread_sel", 64'(thread_sel), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        reset_n = 1'b1;

        // thread 2 alone, 4 words, no stalls
        add_pkt(2, 4);
        run_phase(50, 5);

        // thread 3 stalls mid-packet while thread 1 waits
        add_pkt(3, 4); add_pkt(1, 2);
        set_masks(3, 2, 3, -1, 0, 1'b0);
        run_phase(60, 11);
        exp_order = {3, 1};
        chk_order();

        // single-word packet on thread 7
        set_masks(-1, 0, 0, -1, 0, 1'b0);
        add_pkt(7, 1);
        run_phase(20, 2);

        // every thread busy: full rotation back to thread 0
        for (int t = 0; t < NT; t++) add_pkt(t, 2);
        add_pkt(0, 2);
        run_phase(100, 27);
        exp_order = {0, 1, 2, 3, 4, 5, 6, 7, 0};
        chk_order();

        // thread 5 with downstream back-pressure in packet cycles 2-4
        add_pkt(5, 5);
        set_masks(-1, 0, 0, 2, 3, 1'b0);
        run_phase(60, 9);

        // randomized traffic, stalls and back-pressure
        for (int r = 0; r < 8; r++) begin
            n = 0;
            for (int t = 0; t < NT; t++) begin
                for (int p = $urandom_range(0, 2); p > 0; p--) begin
                    add_pkt(t, $urandom_range(1, 5));
                    n++;
                end
            end
            if (n == 0) add_pkt($urandom_range(0, NT - 1), $urandom_range(1, 5));
            set_masks(-1, 0, 0, -1, 0, 1'b1);
            run_phase(2000, -1);
        end

        // reset during word 2 of a 5-word packet on thread 0
        set_masks(-1, 0, 0, -1, 0, 1'b0);
        add_pkt(0, 5);
        cyc = 0;
        plan();
        step();
        step();
        drive();
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_wr", 64'(out_wr), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
        chk("midrst_pkt_done", 64'(pkt_done), 64'd0);
        chk("midrst_thread_sel", 64'(thread_sel), 64'd0);
        chk("midrst_rd_en", 64'(rd_en), 64'd0);
        @(posedge clk);
        @(negedge clk);
        exp_out.delete(); exp_pop.delete();
        clear_fifos();
        prev_pop = 1'b0; hold_d = '0; hold_c = '0;
        model_last = NT - 1;
        reset_n = 1'b1;
        add_pkt(4, 3); add_pkt(0, 2);
        run_phase(60, 7);
        exp_order = {0, 4};
        chk_order();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/outfifo_arbiter.md
OUTFIFO_ARBITER -- requirements
Module: outfifo_arbiter

Interface
REQ-001 Parameter NUM_THREADS, default 8: number of thread output FIFOs merged onto one stream.
REQ-002 Parameter DATA_WIDTH, default 64: packet word width.
REQ-003 Parameter CTRL_WIDTH, default 8: control sideband width carried with each word.
REQ-004 Ports SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 pkt_avail  in  NUM_THREADS  bit i high = thread i FIFO holds at least one complete packet.
REQ-008 in_valid  in  NUM_THREADS  bit i high = thread i FIFO head word present (first-word-fall-through).
REQ-009 in_last  in  NUM_THREADS  bit i high = thread i head word is the packet's last word.
REQ-010 in_data  in  NUM_THREADS*DATA_WIDTH  head words; thread i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 in_ctrl  in  NUM_THREADS*CTRL_WIDTH  head ctrl; thread i at slice [i*CTRL_WIDTH +: CTRL_WIDTH].
REQ-012 rd_en  out  NUM_THREADS  one-hot-or-zero pop strobe to the thread FIFOs.
REQ-013 out_data  out  DATA_WIDTH  registered output word.
REQ-014 out_ctrl  out  CTRL_WIDTH  registered output ctrl.
REQ-015 out_wr  out  1  registered write strobe; out_data/out_ctrl valid when high.
REQ-016 out_rdy  in  1  downstream can accept a word this cycle.
REQ-017 thread_sel  out  3  index of thread currently granted (registered).
REQ-018 pkt_done  out  NUM_THREADS  one-cycle pulse on bit i after thread i's last word is written out.

Function
REQ-019 FSM states: IDLE, XFER.
REQ-020 IDLE: if pkt_avail nonzero, select winner by round-robin starting at (last_grant+1) mod NUM_THREADS, load thread_sel, enter XFER next cycle; else stay IDLE.
REQ-021 Arbitration SHALL take exactly one cycle in IDLE; no rd_en is asserted in IDLE.
REQ-022 XFER: rd_en[thread_sel] = in_valid[thread_sel] AND out_rdy (combinational); all other rd_en bits 0.
REQ-023 On a cycle with rd_en asserted, next cycle out_wr=1, out_data/out_ctrl = that thread's head word/ctrl (1-cycle latency).
REQ-024 Cycles in XFER without rd_en SHALL produce out_wr=0 next cycle; out_data/out_ctrl hold previous value.
REQ-025 When the popped word has in_last[thread_sel]=1: return to IDLE, last_grant <= thread_sel, pkt_done[thread_sel] pulses in the same cycle out_wr carries that last word.
REQ-026 Grant is packet-granular: thread_sel SHALL NOT change while in XFER regardless of pkt_avail.
REQ-027 in_valid low mid-packet: stall in XFER indefinitely, no pops, no out_wr.
REQ-028 out_rdy low: no pop that cycle; word is not lost or duplicated.
REQ-029 Single-word packet (first word has in_last=1): one out_wr, then IDLE.
REQ-030 Minimum gap between packets: one idle output cycle (IDLE arbitration cycle).
REQ-031 Only pkt_avail bit of the new winner matters; unrequested threads are skipped with no cycle cost.
REQ-032 thread_sel width is 3; NUM_THREADS SHALL be 2..8.

Reset
REQ-033 On reset_n low, asynchronously: state=IDLE, thread_sel=0, last_grant=NUM_THREADS-1 (thread 0 wins first), out_wr=0, out_data=0, out_ctrl=0, pkt_done=0; rd_en=0.
REQ-034 Reset mid-packet abandons the packet; after release arbitration restarts from thread 0 with no partial output.

Verification
REQ-035 Thread 2 only, 4-word packet, out_rdy=1: rd_en[2] 4 consecutive cycles after 1 arbitration cycle; out_wr 4 cycles, 1 cycle delayed; pkt_done[2] with 4th word; thread_sel=2.
REQ-036 All 8 pkt_avail high, 2-word packets each: grant order 0,1,2,...,7,0; each packet contiguous, one idle cycle between.
REQ-037 Thread 5 granted, out_rdy low cycles 2-4 of packet: rd_en and out_wr gapped accordingly; output word sequence identical to input, no duplicates.
REQ-038 Thread 3 mid-packet, in_valid[3] low 3 cycles while pkt_avail[1] high: no switch to thread 1; thread 3 completes, then thread 1 granted.
REQ-039 Single-word packet on thread 7 with in_last=1: exactly one out_wr, pkt_done[7] same cycle, FSM back to IDLE.
REQ-040 reset_n pulled low during word 2 of a 5-word packet: all outputs 0 immediately; after release with pkt_avail[0,4] high, thread 0 granted first.
